// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Grant index width for 2..16 requesters; never narrower than one bit.
    function automatic int unsigned grant_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the NIN input streams and the single registered output stream.
interface stream_rr_arbiter_if
    import stream_arb_pkg::*;
#(
    parameter int unsigned NIN = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned IW  = grant_width(NIN)
);

    logic [NIN-1:0]    i_valid;
    logic [NIN-1:0]    o_ready;
    logic [NIN*DW-1:0] i_data;
    logic [NIN-1:0]    i_last;
    logic              o_valid;
    logic              i_ready;
    logic [DW-1:0]     o_data;
    logic              o_last;
    logic [IW-1:0]     o_grant;
    logic              o_busy;

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_data, o_last, o_grant, o_busy
    );

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_grant, o_busy
    );

endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the pointer, wrapping at NIN.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int unsigned NIN = 4,
    parameter int unsigned IW  = grant_width(NIN)
) (
    input  logic [NIN-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic           found,
    output logic [IW-1:0]  idx
);

    // Modular add; both operands are always below NIN.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (IW+1)'(NIN)) begin
            sum = sum - (IW+1)'(NIN);
        end
        return sum[IW-1:0];
    endfunction

    logic [IW-1:0]  start;
    logic [IW-1:0]  offset;
    logic [NIN-1:0] rot;

    always_comb begin
        start = wrap_add(ptr, IW'(1));
        rot   = '0;
        for (int i = 0; i < NIN; i++) begin
            rot[i] = req[wrap_add(start, IW'(i))];
        end
        offset = '0;
        for (int i = NIN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IW'(i);
            end
        end
        found = |rot;
        idx   = wrap_add(start, offset);
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one registered valid/ready stream among NIN inputs.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int unsigned NIN          = 4,
    parameter int unsigned DW           = 8,
    parameter bit          OPT_LOWPOWER = 1'b0,
    parameter int unsigned IW           = grant_width(NIN)
) (
    input logic                i_clk,
    input logic                i_reset,
    stream_rr_arbiter_if.slave bus
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;

    logic           out_free;
    logic           accept;
    logic [NIN-1:0] ready;
    logic [DW-1:0]  sel_data;
    logic           sel_last;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [IW-1:0] out_grant_q, out_grant_d;

    rr_pick #(
        .NIN (NIN),
        .IW  (IW)
    ) u_pick (
        .req   (bus.i_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Output slot can take a new beat when empty or being drained this cycle.
    assign out_free = !out_valid_q || bus.i_ready;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NIN; k++) begin
            if (grant_q == IW'(k)) begin
                sel_data = bus.i_data[k*DW +: DW];
            end
        end
        sel_last = bus.i_last[grant_q];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NIN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    grant_d = pick_idx;
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready  = '0;
        accept = 1'b0;
        if (state_q == LOCKED) begin
            ready[grant_q] = out_free;
            accept         = out_free && bus.i_valid[grant_q];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_grant_d = out_grant_q;
        if (out_free) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d  = sel_data;
                out_last_d  = sel_last;
                out_grant_d = grant_q;
            end else if (OPT_LOWPOWER) begin
                out_data_d = '0;
                out_last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_grant_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_grant_q <= out_grant_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = out_valid_q;
    assign bus.o_data  = out_data_q;
    assign bus.o_last  = out_last_q;
    assign bus.o_grant = out_grant_q;
    assign bus.o_busy  = (state_q == LOCKED);

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin, packet-locked arbiter that shares one valid/ready output stream among NIN valid/ready input streams. Each requester keeps the grant until the beat carrying its last flag is accepted. The output is registered with full-throughput handshaking, so the block can sit directly in front of a downstream stream stage without a combinational ready-to-valid path toward the sink.

## Interface
Parameters:
- NIN, 4: number of input streams, 2..16.
- DW, 8: data width per stream.
- OPT_LOWPOWER, 0: when 1, o_data and o_last are forced to 0 whenever o_valid is 0.
- IW, $clog2(NIN): grant index width. Derived; do not override.

Ports:
- i_clk, input, 1: clock. One clock domain.
- i_reset, input, 1: synchronous, active-high reset.
- i_valid, input, NIN: per-stream valid.
- o_ready, output, NIN: per-stream ready. At most one bit is high.
- i_data, input, NIN*DW: stream k occupies bits [k*DW +: DW].
- i_last, input, NIN: per-stream end-of-packet flag.
- o_valid, output, 1: output valid (registered).
- i_ready, input, 1: output ready from the sink.
- o_data, output, DW: output data (registered).
- o_last, output, 1: output end-of-packet (registered).
- o_grant, output, IW: index of the stream that sourced the current output beat (registered).
- o_busy, output, 1: high while in the LOCKED state.

## Operation
- Two states, IDLE and LOCKED, plus a grant register g and a last-served pointer p.
- **IDLE:** if any i_valid is set, choose the first set bit searching p+1, p+2, … modulo NIN. Load g with it and go to LOCKED. If no i_valid is set, stay in IDLE. In IDLE, o_ready is all zero.
- **LOCKED:**
  - o_ready[g] = !o_valid || i_ready. All other o_ready bits are 0.
  - A beat is accepted when i_valid[g] && o_ready[g]. The output register then loads i_data[g], i_last[g] and g.
  - Accepting a beat with i_last[g]=1 moves the state to IDLE and sets p to g.
  - If i_valid[g] drops mid-packet, stay LOCKED and wait. There is no timeout.
- **Output register:**
  - When !o_valid || i_ready: o_valid is set to the accept condition.
  - If no beat is accepted in that cycle, o_data and o_last keep their values, or are zeroed when OPT_LOWPOWER=1.
  - While o_valid && !i_ready: o_valid, o_data, o_last and o_grant are held stable.
- **Protocol requirements on requesters:**
  - i_valid && !o_ready implies i_valid is held and i_data/i_last are stable in the next cycle.
  - A raised i_valid is never withdrawn before acceptance.
  - The block guarantees the same rules on its output.
- Fairness: each requester with i_valid held is granted within NIN-1 packets of the other requesters.

## Timing
- Reset values:
  - o_valid=0, o_data=0, o_last=0, o_grant=0, o_busy=0, o_ready=0.
  - state=IDLE, p=NIN-1, so stream 0 has first priority.
- Arbitration takes 1 cycle: IDLE with a request is followed by LOCKED, and the first o_ready[g] is high in the next cycle.
- Latency is 1 cycle from beat acceptance to o_valid with that beat.
- Throughput:
  - Within a packet, one beat per cycle when i_ready stays high.
  - Between packets there is one bubble cycle for the IDLE arbitration.
- Simultaneous events:
  - A last-beat accept and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle using the updated p.
  - Output stalled (o_valid && !i_ready) in LOCKED: o_ready[g]=0, so there is no accept.
- Reset mid-packet:
  - Next cycle: IDLE, o_valid=0, o_ready=0, p=NIN-1.
  - The partial packet is dropped and there is no last-beat completion.
- Single-beat packet (i_last on the first beat): LOCKED lasts exactly 1 cycle if the output is not stalled.

## Structure
- Package stream_arb_pkg holds:
  - the state enum, IDLE=1'b0 and LOCKED=1'b1;
  - a function for the grant index width, for NIN up to 16.
- One sub-module is natural: rr_pick.
  - Purely combinational. Inputs: request vector and pointer p. Outputs: found flag and index.
  - Implemented as a rotate, priority encode, un-rotate.
- Everything else (FSM, output register, data mux) stays in the top module.

## Test plan
- **Reset priority:**
  - Stimulus: out of reset, i_valid=4'b1111, all i_last=1, i_ready=1.
  - Required: o_grant sequence 0,1,2,3,0, one beat per 2 cycles.
- **Packet lock:**
  - Stimulus: stream 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last on 0xA2) while stream 0 requests.
  - Required: output 0xA0, 0xA1, 0xA2 with o_grant=2 and o_last only on 0xA2; stream 0 is granted next.
- **Backpressure:**
  - Stimulus: i_ready=0 for 3 cycles during a packet.
  - Required: o_valid, o_data and o_grant are held; o_ready[g]=0; no beats are lost or duplicated after release.
- **Requester gap:**
  - Stimulus: stream 1 drops i_valid for 2 cycles between beats.
  - Required: the block stays LOCKED with o_busy=1; the other streams get no o_ready.
- **Reset mid-packet:**
  - Stimulus: assert i_reset after beat 1 of 4.
  - Required: next cycle o_valid=0 and o_busy=0; with all streams requesting, the next grant goes to stream 0.
- **Random soak (OPT_LOWPOWER=1):**
  - Stimulus: random valid/ready traffic.
  - Required: per-stream packet contents match a scoreboard; o_data=0 whenever o_valid=0; no starvation beyond NIN-1 packets.
